random_ms: RTL and testbench



---
 rtl/random_ms_if.sv | 22 ++
 rtl/random_ms.sv | 241 ++++++++++++++++++++++++
 tb/tb_random_ms.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/random_ms_if.sv
// Wishbone classic slave bus bundle for the random_ms generator.
// Signal suffixes follow the slave's point of view.
interface random_ms_if;
  logic        cs_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;
  logic        we_i;
  logic [4:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;

  modport master (
    output cs_i, cyc_i, stb_i, we_i, adr_i, dat_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  cs_i, cyc_i, stb_i, we_i, adr_i, dat_i,
    output ack_o, dat_o
  );
endinterface

// File: rtl/random_ms.sv
// Multi-stream PRNG (MWC / xorshift32+Weyl) behind a Wishbone slave.
// Per-stream {z,w} lives in a self-initialising RAM; the active stream is cached.
module random_ms #(
  parameter int          STREAMS = 1024,
  parameter int          SB      = $clog2(STREAMS),
  parameter logic [31:0] Z_INIT  = 32'd17,
  parameter logic [31:0] W_INIT  = 32'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  random_ms_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACC, S_LOAD, S_LATCH, S_ADV, S_ACK
  } state_t;

  localparam logic [2:0] A_NUM  = 3'd0;
  localparam logic [2:0] A_STRM = 3'd1;
  localparam logic [2:0] A_ZSD  = 3'd2;
  localparam logic [2:0] A_WSD  = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;

  state_t        r_state, w_next;
  logic [SB-1:0] r_idx;
  logic          r_boot;
  logic          r_we;
  logic [2:0]    r_adr;
  logic [31:0]   r_din;
  logic [SB-1:0] r_stream;
  logic [2:0]    r_ctrl;
  logic          r_zflt;
  logic          r_auto;
  logic [31:0]   r_z, r_w;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic [63:0]   r_ram [STREAMS];
  logic [63:0]   r_rd;

  logic          w_req;
  logic [31:0]   w_num, w_num_rd, w_rdata;
  logic [31:0]   w_mz, w_mw, w_t1, w_t2, w_xz, w_xw;
  logic [31:0]   w_nz, w_nw, w_zs, w_ws;
  logic          w_busy;
  logic          w_ack_nxt;
  logic [31:0]   w_dat_nxt;
  logic          w_ram_we;
  logic [SB-1:0] w_ram_wa;
  logic [63:0]   w_ram_wd;
  logic          w_unused_adr;

  assign w_unused_adr = &{1'b0, bus.adr_i[1:0]};
  assign w_req = bus.cs_i & bus.cyc_i & bus.stb_i;

  assign w_mz = 32'd36969 * {16'h0, r_z[15:0]} + {16'h0, r_z[31:16]};
  assign w_mw = 32'd18000 * {16'h0, r_w[15:0]} + {16'h0, r_w[31:16]};
  assign w_t1 = r_z ^ (r_z << 13);
  assign w_t2 = w_t1 ^ (w_t1 >> 17);
  assign w_xz = w_t2 ^ (w_t2 << 5);
  assign w_xw = r_w + 32'h9E37_79B9;
  assign w_nz = r_ctrl[2] ? w_xz : w_mz;
  assign w_nw = r_ctrl[2] ? w_xw : w_mw;

  assign w_num = r_ctrl[2] ? (r_z + r_w)
                           : ({r_z[15:0], 16'h0} + r_w);
  assign w_num_rd = r_ctrl[1]
    ? {w_num[7:0], w_num[15:8], w_num[23:16], w_num[31:24]}
    : w_num;

  // Zero seeds would lock the generators; substitute the base seed.
  assign w_zs = (r_din == 32'h0) ? Z_INIT : r_din;
  assign w_ws = (r_din == 32'h0) ? W_INIT : r_din;

  assign w_busy = (r_state != S_IDLE) && (r_state != S_ACC);

  always_comb begin
    w_rdata = 32'h0;
    case (r_adr)
      A_NUM:   w_rdata = w_num_rd;
      A_STRM:  w_rdata = 32'(r_stream);
      A_CTRL:  w_rdata = {29'h0, r_ctrl};
      A_STAT:  w_rdata = {30'h0, r_zflt, w_busy};
      default: w_rdata = 32'h0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_ack_nxt = 1'b0;
    w_dat_nxt = 32'h0;
    w_ram_we  = 1'b0;
    w_ram_wa  = r_stream;
    w_ram_wd  = {r_z, r_w};
    unique case (r_state)
      S_INIT: begin
        w_ram_we = 1'b1;
        w_ram_wa = r_idx;
        w_ram_wd = {Z_INIT + 32'(r_idx), W_INIT + 32'(r_idx)};
        if (r_idx == SB'(STREAMS - 1)) w_next = S_LOAD;
      end
      S_IDLE: begin
        if (w_req && !r_ack) w_next = S_ACC;
      end
      S_ACC: begin
        if (!r_we) begin
          w_next    = S_ACK;
          w_ack_nxt = w_req;
          w_dat_nxt = w_req ? w_rdata : 32'h0;
        end else begin
          w_next    = S_ACK;
          w_ack_nxt = w_req;
          case (r_adr)
            A_NUM: begin
              w_next    = S_ADV;
              w_ack_nxt = 1'b0;
            end
            A_STRM: begin
              w_next    = S_LOAD;
              w_ack_nxt = 1'b0;
            end
            A_ZSD: begin
              w_ram_we = 1'b1;
              w_ram_wd = {w_zs, r_w};
            end
            A_WSD: begin
              w_ram_we = 1'b1;
              w_ram_wd = {r_z, w_ws};
            end
            default: ;
          endcase
        end
      end
      S_LOAD: w_next = S_LATCH;
      S_LATCH: begin
        if (r_boot) begin
          w_next = S_IDLE;
        end else begin
          w_next    = S_ACK;
          w_ack_nxt = w_req;
        end
      end
      S_ADV: begin
        w_ram_we = 1'b1;
        w_ram_wd = {w_nz, w_nw};
        if (r_auto) begin
          w_next = S_IDLE;
        end else begin
          w_next    = S_ACK;
          w_ack_nxt = w_req;
        end
      end
      S_ACK: begin
        if (w_req) begin
          w_ack_nxt = 1'b1;
          w_dat_nxt = r_dat;
        end else begin
          w_next = r_auto ? S_ADV : S_IDLE;
        end
      end
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx    <= '0;
      r_boot   <= 1'b1;
      r_we     <= 1'b0;
      r_adr    <= 3'h0;
      r_din    <= 32'h0;
      r_stream <= '0;
      r_ctrl   <= 3'h0;
      r_zflt   <= 1'b0;
      r_auto   <= 1'b0;
      r_z      <= Z_INIT;
      r_w      <= W_INIT;
      r_ack    <= 1'b0;
      r_dat    <= 32'h0;
    end else begin
      r_ack <= w_ack_nxt;
      r_dat <= w_dat_nxt;
      case (r_state)
        S_INIT: r_idx <= r_idx + SB'(1);
        S_IDLE: begin
          if (w_req && !r_ack) begin
            r_we  <= bus.we_i;
            r_adr <= bus.adr_i[4:2];
            r_din <= bus.dat_i;
          end
        end
        S_ACC: begin
          if (!r_we) begin
            r_auto <= (r_adr == A_NUM) && r_ctrl[0];
          end else begin
            case (r_adr)
              A_STRM: r_stream <= r_din[SB-1:0];
              A_ZSD: begin
                r_z <= w_zs;
                if (r_din == 32'h0) r_zflt <= 1'b1;
              end
              A_WSD: begin
                r_w <= w_ws;
                if (r_din == 32'h0) r_zflt <= 1'b1;
              end
              A_CTRL: r_ctrl <= r_din[2:0];
              A_STAT: if (r_din[1]) r_zflt <= 1'b0;
              default: ;
            endcase
          end
        end
        S_LATCH: begin
          r_z    <= r_rd[63:32];
          r_w    <= r_rd[31:0];
          r_boot <= 1'b0;
        end
        S_ADV: begin
          r_z    <= w_nz;
          r_w    <= w_nw;
          r_auto <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State RAM: no reset, contents are rebuilt by INIT.
  always_ff @(posedge clk_i) begin
    if (w_ram_we) r_ram[w_ram_wa] <= w_ram_wd;
    r_rd <= r_ram[r_stream];
  end

  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;

endmodule

// File: tb/tb_random_ms.sv
// Directed vector bench for random_ms.
// Table of bus accesses plus hand-written reset/auto/INIT sequences.
module tb_random_ms;

  localparam int STREAMS = 1024;
  localparam int LIM     = 40;

  localparam logic [2:0] R_NUM  = 3'd0;
  localparam logic [2:0] R_STRM = 3'd1;
  localparam logic [2:0] R_ZSD  = 3'd2;
  localparam logic [2:0] R_WSD  = 3'd3;
  localparam logic [2:0] R_CTRL = 3'd4;
  localparam logic [2:0] R_STAT = 3'd5;
  localparam logic [2:0] R_RSV6 = 3'd6;
  localparam logic [2:0] R_RSV7 = 3'd7;

  typedef struct {
    logic        we;
    logic [2:0]  ra;
    logic [31:0] d;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  random_ms_if bus ();

  random_ms #(.STREAMS(STREAMS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cs_i  = 1'b0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 5'h0;
    bus.dat_i = 32'h0;
  endtask

  task automatic bus_op(input logic we, input logic [2:0] ra,
                        input logic [31:0] d, input int lim,
                        output logic [31:0] q, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    bus.cs_i  = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = {ra, 2'b00};
    bus.dat_i = d;
    for (int i = 0; i < lim && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ack_o) got = 1'b1;
    end
    q = bus.dat_o;
    chk("ack_seen", {31'h0, got}, 32'h1);
    bus_idle();
    @(posedge clk);
    #1;
    chk("ack_drop", {31'h0, bus.ack_o}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t        v [NV];
  logic [31:0] q;
  int          lat;

  initial begin
    bus_idle();
    v[0]  = '{1'b0, R_STAT, 32'h0, 32'h0000_0000, 2};
    v[1]  = '{1'b0, R_NUM,  32'h0, 32'h0011_0003, 2};
    v[2]  = '{1'b1, R_NUM,  32'h0, 32'h0, 3};
    v[3]  = '{1'b0, R_NUM,  32'h0, 32'h96F9_D2F0, 2};
    v[4]  = '{1'b1, R_STRM, 32'h5, 32'h0, 4};
    v[5]  = '{1'b0, R_STRM, 32'h0, 32'h0000_0005, 2};
    v[6]  = '{1'b0, R_NUM,  32'h0, 32'h0016_0008, 2};
    v[7]  = '{1'b1, R_STRM, 32'h0, 32'h0, 4};
    v[8]  = '{1'b0, R_NUM,  32'h0, 32'h96F9_D2F0, 2};
    v[9]  = '{1'b1, R_CTRL, 32'h4, 32'h0, 2};
    v[10] = '{1'b0, R_CTRL, 32'h0, 32'h0000_0004, 2};
    v[11] = '{1'b1, R_ZSD,  32'h1, 32'h0, 2};
    v[12] = '{1'b1, R_WSD,  32'h3, 32'h0, 2};
    v[13] = '{1'b1, R_NUM,  32'h0, 32'h0, 3};
    v[14] = '{1'b0, R_NUM,  32'h0, 32'h9E3B_99DD, 2};
    v[15] = '{1'b1, R_CTRL, 32'h6, 32'h0, 2};
    v[16] = '{1'b0, R_NUM,  32'h0, 32'hDD99_3B9E, 2};
    v[17] = '{1'b1, R_CTRL, 32'h0, 32'h0, 2};
    v[18] = '{1'b1, R_ZSD,  32'h0, 32'h0, 2};
    v[19] = '{1'b0, R_STAT, 32'h0, 32'h0000_0002, 2};
    v[20] = '{1'b0, R_NUM,  32'h0, 32'h9E48_79BC, 2};
    v[21] = '{1'b1, R_STAT, 32'h2, 32'h0, 2};
    v[22] = '{1'b0, R_STAT, 32'h0, 32'h0000_0000, 2};
    v[23] = '{1'b1, R_RSV7, 32'hFFFF_FFFF, 32'h0, 2};
    v[24] = '{1'b0, R_RSV6, 32'h0, 32'h0000_0000, 2};

    do_reset();
    chk("rst_ack", {31'h0, bus.ack_o}, 32'h0);
    chk("rst_dat", bus.dat_o, 32'h0);
    repeat (STREAMS + 3) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      bus_op(v[i].we, v[i].ra, v[i].d, LIM, q, lat);
      if (!v[i].we) chk($sformatf("v%0d_data", i), q, v[i].exp);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
    end
    bus_op(1'b0, R_ZSD, 32'h0, LIM, q, lat);
    chk("zseed_reads0", q, 32'h0);

    do_reset();
    repeat (STREAMS + 3) @(posedge clk);
    #1;
    bus_op(1'b1, R_CTRL, 32'h1, LIM, q, lat);
    bus_op(1'b0, R_NUM, 32'h0, LIM, q, lat);
    chk("auto0_data", q, 32'h0011_0003);
    chk("auto0_lat", lat, 2);
    bus_op(1'b0, R_NUM, 32'h0, LIM, q, lat);
    chk("auto1_data", q, 32'h96F9_D2F0);
    chk("auto1_lat", lat, 3);
    bus_op(1'b0, R_NUM, 32'h0, LIM, q, lat);
    chk("auto2_data", q, 32'h3619_8B00);
    chk("auto2_lat", lat, 3);

    do_reset();
    repeat (3) @(posedge clk);
    #1;
    bus_op(1'b0, R_NUM, 32'h0, STREAMS + 20, q, lat);
    chk("init_data", q, 32'h0011_0003);
    chk("init_held", {31'h0, lat > STREAMS}, 32'h1);

    bus.cs_i  = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = {R_NUM, 2'b00};
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_ack", {31'h0, bus.ack_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_ack_async", {31'h0, bus.ack_o}, 32'h0);
    chk("rst_dat_async", bus.dat_o, 32'h0);
    bus_idle();
    do_reset();
    repeat (STREAMS + 3) @(posedge clk);
    #1;

    bus.cs_i  = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = {R_NUM, 2'b00};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("adv_rst_ack", {31'h0, bus.ack_o}, 32'h0);
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_op(1'b0, R_NUM, 32'h0, STREAMS + 20, q, lat);
    chk("reinit_data", q, 32'h0011_0003);
    chk("reinit_held", {31'h0, lat > STREAMS}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
